// File: rtl/makestuff_c2f_arbiter_pkg.sv
// makestuff_c2f_arbiter_pkg
// Local definitions for the C2F chunk arbiter: the ownership state machine
// encoding and the largest number of consumers the arbiter is built for.
// No ports (package only).
package makestuff_c2f_arbiter_pkg;

  localparam int MAX_CONSUMERS = 4;

  // S_IDLE: nobody owns the read port, arbitration may run.
  // S_OWNED: one consumer owns the current chunk until it acknowledges.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } ArbState;

endpackage

// File: rtl/makestuff_tlp_xcvr_pkg.sv
// makestuff_tlp_xcvr_pkg
// Shared definitions for the TLP transceiver and its C2F / F2C helpers.
// The C2F ring buffer is addressed as {chunk pointer, offset within chunk}:
// the chunk pointer names one of 2**C2F_PTR_WIDTH chunks and the offset names
// one of C2F_CHUNKSIZE words inside that chunk.
// No ports (package only).
package makestuff_tlp_xcvr_pkg;

  localparam int C2F_PTR_WIDTH    = 3;
  localparam int C2F_OFFSET_WIDTH = 4;
  localparam int C2F_CHUNKSIZE    = 2 ** C2F_OFFSET_WIDTH;

  typedef logic [C2F_PTR_WIDTH-1:0]    C2FChunkPtr;
  typedef logic [C2F_OFFSET_WIDTH-1:0] C2FChunkOffset;
  typedef logic [31:0]                 uint32;

endpackage

// File: rtl/makestuff_rr_picker.sv
// makestuff_rr_picker
// Purely combinational round-robin selector. Starting just after the last
// winner and wrapping in ascending index order, it returns the first
// requester found. Shared between the C2F and F2C arbiters.
// Ports:
//   reqMask_i    request mask, one bit per requester
//   lastIdx_i    index of the previous winner (search starts after it)
//   winOneHot_o  one-hot winner, zero when nobody requests
//   winIdx_o     binary index of the winner, zero when nobody requests
//   valid_o      high when at least one requester was found
module makestuff_rr_picker #(
  parameter int N    = 2,
  parameter int IDXW = 1
) (
  input  logic [N-1:0]    reqMask_i,
  input  logic [IDXW-1:0] lastIdx_i,
  output logic [N-1:0]    winOneHot_o,
  output logic [IDXW-1:0] winIdx_o,
  output logic            valid_o
);

  logic            found;
  logic [IDXW-1:0] cand;

  // Walk the requesters in priority order (last+1, last+2, ... wrapping) and
  // latch onto the first one that is requesting. The previous winner is
  // visited last, which is what makes the scheme fair.
  always_comb begin
    found       = 1'b0;
    cand        = '0;
    winOneHot_o = '0;
    winIdx_o    = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IDXW'((int'(lastIdx_i) + off) % N);
      if (!found && reqMask_i[cand]) begin
        found             = 1'b1;
        winOneHot_o[cand] = 1'b1;
        winIdx_o          = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/makestuff_c2f_arbiter.sv
// makestuff_c2f_arbiter
// Shares the C2F chunk ring buffer, and its single RAM read port, between
// NUM_CONSUMERS chunk consumers (legal range 1..MAX_CONSUMERS). The arbiter
// owns the ring read pointer, hands out whole chunks round-robin to enabled
// consumers, forms the RAM read address from the read pointer plus the
// owner's offset, and retires a chunk when its owner acknowledges it.
// Ports:
//   sysClk_in       system clock
//   sysRst_in       asynchronous active-high reset
//   wrPtr_in        producer write pointer
//   rdPtr_out       registered read pointer, returned to the producer as credit
//   ramRdAddr_out   RAM read address {rdPtr, owner offset}; {rdPtr, 0} when idle
//   enable_in       per-consumer eligibility mask (affects arbitration only)
//   cWrPtr_out      per-consumer write pointer view (flattened)
//   cRdPtr_out      per-consumer read pointer view (flattened)
//   cDtAck_in       per-consumer chunk-done pulse
//   cRdOffset_in    per-consumer read offset within the chunk (flattened)
//   grant_out       one-hot current owner, zero when idle
//   chunkCount_out  completed chunks per consumer, 32 bits each (flattened)
//   protoErr_out    sticky protocol error flag
//   errClear_in     synchronous clear of protoErr_out
module makestuff_c2f_arbiter
  import makestuff_tlp_xcvr_pkg::*;
  import makestuff_c2f_arbiter_pkg::*;
#(
  parameter int NUM_CONSUMERS = 2
) (
  input  logic                                         sysClk_in,
  input  logic                                         sysRst_in,
  input  logic [C2F_PTR_WIDTH-1:0]                     wrPtr_in,
  output logic [C2F_PTR_WIDTH-1:0]                     rdPtr_out,
  output logic [C2F_PTR_WIDTH+C2F_OFFSET_WIDTH-1:0]    ramRdAddr_out,
  input  logic [NUM_CONSUMERS-1:0]                     enable_in,
  output logic [NUM_CONSUMERS*C2F_PTR_WIDTH-1:0]       cWrPtr_out,
  output logic [NUM_CONSUMERS*C2F_PTR_WIDTH-1:0]       cRdPtr_out,
  input  logic [NUM_CONSUMERS-1:0]                     cDtAck_in,
  input  logic [NUM_CONSUMERS*C2F_OFFSET_WIDTH-1:0]    cRdOffset_in,
  output logic [NUM_CONSUMERS-1:0]                     grant_out,
  output logic [NUM_CONSUMERS*32-1:0]                  chunkCount_out,
  output logic                                         protoErr_out,
  input  logic                                         errClear_in
);

  localparam int PW = C2F_PTR_WIDTH;
  localparam int OW = C2F_OFFSET_WIDTH;
  localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  ArbState                           state_q, state_d;
  logic [NUM_CONSUMERS-1:0]          grant_q, grant_d;
  logic [IW-1:0]                     ownerIdx_q, ownerIdx_d;
  C2FChunkPtr                        rdPtr_q, rdPtr_d;
  logic [NUM_CONSUMERS-1:0][31:0]    chunkCount_q, chunkCount_d;
  logic                              protoErr_q, protoErr_d;

  logic [NUM_CONSUMERS-1:0]          pickOneHot;
  logic [IW-1:0]                     pickIdx;
  logic                              pickValid;

  logic [NUM_CONSUMERS-1:0]          ownerMask;
  logic                              ownerAck;
  logic                              errSet;
  logic                              ringEmpty;
  C2FChunkOffset                     ownerOffset;

  // ownerIdx_q doubles as the "last winner" for the round-robin search: it
  // keeps its value after the chunk is retired, so the next search starts
  // just after the consumer that was served last.
  makestuff_rr_picker #(
    .N    (NUM_CONSUMERS),
    .IDXW (IW)
  ) u_picker (
    .reqMask_i   (enable_in),
    .lastIdx_i   (ownerIdx_q),
    .winOneHot_o (pickOneHot),
    .winIdx_o    (pickIdx),
    .valid_o     (pickValid)
  );

  // Only an ack from the current owner while owned can retire a chunk; any
  // other set ack bit is a protocol violation. This single mask covers
  // acks in idle, acks from non-owners and multiple simultaneous acks.
  assign ownerMask = (state_q == S_OWNED) ? grant_q : '0;
  assign ownerAck  = |(cDtAck_in & ownerMask);
  assign errSet    = |(cDtAck_in & ~ownerMask);
  assign ringEmpty = (wrPtr_in == rdPtr_q);

  // Ownership state machine: arbitrate in idle, wait for the owner's ack
  // in owned. Re-arbitration is deliberately left to the idle state, which
  // gives a fixed two-edge gap between an ack and the next grant.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ownerIdx_d   = ownerIdx_q;
    rdPtr_d      = rdPtr_q;
    chunkCount_d = chunkCount_q;
    case (state_q)
      S_IDLE: begin
        if (!ringEmpty && pickValid) begin
          grant_d    = pickOneHot;
          ownerIdx_d = pickIdx;
          state_d    = S_OWNED;
        end
      end
      S_OWNED: begin
        if (ownerAck) begin
          rdPtr_d                  = rdPtr_q + 1'b1;
          chunkCount_d[ownerIdx_q] = chunkCount_q[ownerIdx_q] + 32'd1;
          grant_d                  = '0;
          state_d                  = S_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Sticky error flag: a new violation in the same cycle beats a clear.
  always_comb begin
    protoErr_d = protoErr_q;
    if (errSet) begin
      protoErr_d = 1'b1;
    end else if (errClear_in) begin
      protoErr_d = 1'b0;
    end
  end

  // State registers. Reset abandons any chunk in flight without counting it
  // and primes the last winner so that consumer 0 is served first.
  always_ff @(posedge sysClk_in or posedge sysRst_in) begin
    if (sysRst_in) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      ownerIdx_q   <= IW'(NUM_CONSUMERS - 1);
      rdPtr_q      <= '0;
      chunkCount_q <= '0;
      protoErr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ownerIdx_q   <= ownerIdx_d;
      rdPtr_q      <= rdPtr_d;
      chunkCount_q <= chunkCount_d;
      protoErr_q   <= protoErr_d;
    end
  end

  // Read address: the owner steers the word offset inside the current chunk;
  // with no owner the address parks at the start of the chunk.
  always_comb begin
    ownerOffset = '0;
    if (state_q == S_OWNED) begin
      ownerOffset = cRdOffset_in[int'(ownerIdx_q)*OW +: OW];
    end
  end

  // Consumer pointer views: everyone except the owner sees an empty ring
  // (write pointer == read pointer), so only the owner believes data exists.
  always_comb begin
    cWrPtr_out = '0;
    cRdPtr_out = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      cRdPtr_out[i*PW +: PW] = rdPtr_q;
      cWrPtr_out[i*PW +: PW] = ownerMask[IW'(i)] ? wrPtr_in : rdPtr_q;
    end
  end

  assign rdPtr_out      = rdPtr_q;
  assign ramRdAddr_out  = {rdPtr_q, ownerOffset};
  assign grant_out      = grant_q;
  assign chunkCount_out = chunkCount_q;
  assign protoErr_out   = protoErr_q;

endmodule
